cw_datapath: RTL and testbench



---
 rtl/cw_datapath_if.sv | 27 ++
 rtl/cw_datapath.sv | 127 ++++++++++++
 tb/tb_cw_datapath.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cw_datapath_if.sv
// Control-word bus between the lab top level and cw_datapath.
// The master builds and strobes words; the slave executes them and reports status.
interface cw_datapath_if #(
    parameter int WIDTH = 8
);
    logic [15:0]      control_word;
    logic             cw_valid;
    logic [WIDTH-1:0] Data_in;
    logic [WIDTH-1:0] constant_in;
    logic [WIDTH-1:0] Data_out;
    logic [WIDTH-1:0] Address_out;
    logic             done;
    logic             V;
    logic             C;
    logic             N;
    logic             Z;

    modport master (
        output control_word, cw_valid, Data_in, constant_in,
        input  Data_out, Address_out, done, V, C, N, Z
    );

    modport slave (
        input  control_word, cw_valid, Data_in, constant_in,
        output Data_out, Address_out, done, V, C, N, Z
    );
endinterface

// File: rtl/cw_datapath.sv
// Register file, function unit and bus muxes executing one control word per strobe.
// Define CW_DATAPATH_SHIFT_EN to give FS 1101/1110 a one-bit shifter on B.
module cw_datapath #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8
) (
    input logic         clk,
    input logic         reset,
    cw_datapath_if.slave bus
);
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       mb;
    logic [3:0] fs;
    logic       md;
    logic       rw;

    assign {da, aa, ba, mb, fs, md, rw} = bus.control_word;

    logic [WIDTH-1:0] rf [NREG];

    logic [WIDTH-1:0] a_bus;
    logic [WIDTH-1:0] b_bus;
    logic [WIDTH-1:0] d_bus;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum;
    logic             cin;
    logic             arith;
    logic             fc;
    logic             fv;

    assign a_bus = rf[aa];
    assign b_bus = mb ? bus.constant_in : rf[ba];

    // All arithmetic codes share one adder: A + y + cin.
    always_comb begin
        y     = '0;
        cin   = 1'b0;
        arith = 1'b1;
        unique case (fs)
            4'b0001: cin = 1'b1;
            4'b0010: y = b_bus;
            4'b0011: begin
                y   = b_bus;
                cin = 1'b1;
            end
            4'b0100: y = ~b_bus;
            4'b0101: begin
                y   = ~b_bus;
                cin = 1'b1;
            end
            4'b0110: y = '1;
            default: arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, a_bus} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        f  = a_bus;
        fc = 1'b0;
        fv = 1'b0;
        if (arith) begin
            f  = sum[WIDTH-1:0];
            fc = sum[WIDTH];
            fv = (a_bus[WIDTH-1] == y[WIDTH-1])
               && (sum[WIDTH-1] != a_bus[WIDTH-1]);
        end else begin
            unique case (fs)
                4'b1000: f = a_bus & b_bus;
                4'b1001: f = a_bus | b_bus;
                4'b1010: f = a_bus ^ b_bus;
                4'b1011: f = ~a_bus;
                4'b1100: f = b_bus;
`ifdef CW_DATAPATH_SHIFT_EN
                4'b1101: begin
                    f  = {1'b0, b_bus[WIDTH-1:1]};
                    fc = b_bus[0];
                end
                4'b1110: begin
                    f  = {b_bus[WIDTH-2:0], 1'b0};
                    fc = b_bus[WIDTH-1];
                end
`else
                4'b1101: f = b_bus;
                4'b1110: f = b_bus;
`endif
                default: f = a_bus;
            endcase
        end
    end

    assign d_bus = md ? bus.Data_in : f;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            bus.Data_out    <= '0;
            bus.Address_out <= '0;
            bus.done        <= 1'b0;
            bus.V           <= 1'b0;
            bus.C           <= 1'b0;
            bus.N           <= 1'b0;
            bus.Z           <= 1'b0;
        end else if (bus.cw_valid) begin
            if (rw) begin
                rf[da] <= d_bus;
            end
            bus.Data_out    <= d_bus;
            bus.Address_out <= a_bus;
            bus.done        <= 1'b1;
            // External loads leave the status of the last F untouched.
            if (!md) begin
                bus.V <= fv;
                bus.C <= fc;
                bus.N <= f[WIDTH-1];
                bus.Z <= (f == '0);
            end
        end else begin
            bus.done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cw_datapath.sv
// Randomized and directed bench for cw_datapath against an integer reference model.
module tb_cw_datapath;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cw_datapath_if #(.WIDTH(8)) bus ();

    cw_datapath #(.WIDTH(8), .NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mreg [8];
    logic [7:0] m_dout;
    logic [7:0] m_aout;
    logic       m_done;
    logic       m_v;
    logic       m_c;
    logic       m_n;
    logic       m_z;

    task automatic ref_alu(input int fs, input int a, input int b,
                           output int f, output int c, output int v);
        int sa;
        int sb;
        int r;
        int s;
        bit ar;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r  = 0;
        s  = 0;
        ar = 1;
        f  = a;
        c  = 0;
        v  = 0;
        case (fs)
            1: begin r = a + 1;             s = sa + 1;       end
            2: begin r = a + b;             s = sa + sb;      end
            3: begin r = a + b + 1;         s = sa + sb + 1;  end
            4: begin r = a + (255 - b);     s = sa - sb - 1;  end
            5: begin r = a + (255 - b) + 1; s = sa - sb;      end
            6: begin r = a + 255;           s = sa - 1;       end
            default: ar = 0;
        endcase
        if (ar) begin
            f = r % 256;
            c = r / 256;
            v = (s > 127 || s < -128) ? 1 : 0;
        end else begin
            case (fs)
                8:  f = a & b;
                9:  f = a | b;
                10: f = a ^ b;
                11: f = 255 - a;
                12: f = b;
`ifdef CW_DATAPATH_SHIFT_EN
                13: begin f = b / 2;         c = b % 2;          end
                14: begin f = (b * 2) % 256; c = (b >= 128) ? 1 : 0; end
`else
                13: f = b;
                14: f = b;
`endif
                default: f = a;
            endcase
        end
    endtask

    task automatic apply(input logic [15:0] cw, input logic [7:0] din,
                         input logic [7:0] k, input logic valid,
                         input logic rst);
        int a;
        int b;
        int f;
        int c;
        int v;
        int d;
        @(negedge clk);
        reset            = rst;
        bus.control_word = cw;
        bus.cw_valid     = valid;
        bus.Data_in      = din;
        bus.constant_in  = k;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
            m_dout = 8'h00;
            m_aout = 8'h00;
            m_done = 1'b0;
            {m_v, m_c, m_n, m_z} = 4'b0000;
        end else if (valid) begin
            a = int'(mreg[cw[12:10]]);
            b = cw[6] ? int'(k) : int'(mreg[cw[9:7]]);
            ref_alu(int'(cw[5:2]), a, b, f, c, v);
            d = cw[1] ? int'(din) : f;
            if (cw[0]) mreg[cw[15:13]] = 8'(d);
            m_dout = 8'(d);
            m_aout = 8'(a);
            m_done = 1'b1;
            if (!cw[1]) begin
                m_v = (v != 0);
                m_c = (c != 0);
                m_n = (f >= 128);
                m_z = (f == 0);
            end
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
        apply(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
        n_tests++;
        if ({bus.Data_out, bus.Address_out, bus.done, bus.V, bus.C,
             bus.N, bus.Z} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got dout=%h aout=%h done=%b vcnz=%b%b%b%b exp all 0",
                     bus.Data_out, bus.Address_out, bus.done,
                     bus.V, bus.C, bus.N, bus.Z);
        end
        for (int r = 0; r < 8; r++) begin
            apply({3'd0, 3'(r), 10'd0}, 8'h00, 8'h00, 1'b1, 1'b0);
            n_tests++;
            if (bus.Address_out !== 8'h00 || bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_reg%0d got aout=%h done=%b exp 00/1",
                         r, bus.Address_out, bus.done);
            end
        end
    endtask

    task automatic test_load();
        apply(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
        apply(16'h0003, 8'h05, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Data_out, bus.done, bus.V, bus.C, bus.N, bus.Z}
            !== {8'h05, 5'b10000}) begin
            n_fail++;
            $display("FAIL load_r0 got dout=%h done=%b vcnz=%b%b%b%b exp 05/1/0000",
                     bus.Data_out, bus.done, bus.V, bus.C, bus.N, bus.Z);
        end
        apply(16'h0003, 8'h77, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if (bus.done !== 1'b0 || bus.Data_out !== 8'h05) begin
            n_fail++;
            $display("FAIL load_done_pulse got done=%b dout=%h exp 0/05",
                     bus.done, bus.Data_out);
        end
        apply(16'h0000, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if (bus.Address_out !== 8'h05) begin
            n_fail++;
            $display("FAIL load_readback got %h exp 05", bus.Address_out);
        end
    endtask

    task automatic test_add();
        apply(16'h2403, 8'hFD, 8'h00, 1'b1, 1'b0);
        apply(16'h4409, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Data_out, bus.Address_out, bus.V, bus.C, bus.N, bus.Z}
            !== {8'h02, 8'hFD, 4'b0100}) begin
            n_fail++;
            $display("FAIL add_carry got dout=%h aout=%h vcnz=%b%b%b%b exp 02/fd/0100",
                     bus.Data_out, bus.Address_out,
                     bus.V, bus.C, bus.N, bus.Z);
        end
        apply(16'h0800, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if (bus.Address_out !== 8'h02) begin
            n_fail++;
            $display("FAIL add_r2 got %h exp 02", bus.Address_out);
        end
    endtask

    task automatic test_overflow();
        apply(16'h0003, 8'h7F, 8'h00, 1'b1, 1'b0);
        apply(16'h2403, 8'h01, 8'h00, 1'b1, 1'b0);
        apply(16'h4409, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Data_out, bus.V, bus.C, bus.N, bus.Z}
            !== {8'h80, 4'b1010}) begin
            n_fail++;
            $display("FAIL add_overflow got dout=%h vcnz=%b%b%b%b exp 80/1010",
                     bus.Data_out, bus.V, bus.C, bus.N, bus.Z);
        end
        // A-1 of zero borrows: C=0; of 0x80 overflows.
        apply(16'h8003, 8'h00, 8'h00, 1'b1, 1'b0);
        apply(16'h9019, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Data_out, bus.V, bus.C, bus.N, bus.Z}
            !== {8'hFF, 4'b0010}) begin
            n_fail++;
            $display("FAIL dec_zero got dout=%h vcnz=%b%b%b%b exp ff/0010",
                     bus.Data_out, bus.V, bus.C, bus.N, bus.Z);
        end
    endtask

    task automatic test_movb_md();
        apply(16'h4071, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Data_out, bus.N, bus.Z} !== {8'h00, 2'b01}) begin
            n_fail++;
            $display("FAIL movb_zero got dout=%h n=%b z=%b exp 00/0/1",
                     bus.Data_out, bus.N, bus.Z);
        end
        apply(16'h0003, 8'h93, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Data_out, bus.N, bus.Z} !== {8'h93, 2'b01}) begin
            n_fail++;
            $display("FAIL md_flags_hold got dout=%h n=%b z=%b exp 93/0/1",
                     bus.Data_out, bus.N, bus.Z);
        end
    endtask

    task automatic test_reset_priority();
        apply(16'h2403, 8'h44, 8'h00, 1'b1, 1'b0);
        apply(16'h0003, 8'h55, 8'h00, 1'b1, 1'b1);
        n_tests++;
        if ({bus.Data_out, bus.Address_out, bus.done, bus.V, bus.C,
             bus.N, bus.Z} !== 21'h0) begin
            n_fail++;
            $display("FAIL rst_prio_out got dout=%h aout=%h done=%b exp 0",
                     bus.Data_out, bus.Address_out, bus.done);
        end
        apply(16'h0000, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Address_out, bus.Z} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_prio_r0 got aout=%h z=%b exp 00/1",
                     bus.Address_out, bus.Z);
        end
        apply(16'h0400, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if (bus.Address_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_prio_r1 got %h exp 00", bus.Address_out);
        end
    endtask

    task automatic test_shift();
        logic [11:0] e_r;
        logic [11:0] e_l;
`ifdef CW_DATAPATH_SHIFT_EN
        e_r = {8'h40, 4'b0100};
        e_l = {8'h02, 4'b0100};
`else
        e_r = {8'h81, 4'b0010};
        e_l = {8'h81, 4'b0010};
`endif
        apply(16'h2403, 8'h81, 8'h00, 1'b1, 1'b0);
        apply(16'h60B5, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Data_out, bus.V, bus.C, bus.N, bus.Z} !== e_r) begin
            n_fail++;
            $display("FAIL shift_right got %h exp %h",
                     {bus.Data_out, bus.V, bus.C, bus.N, bus.Z}, e_r);
        end
        apply(16'h60B9, 8'h00, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({bus.Data_out, bus.V, bus.C, bus.N, bus.Z} !== e_l) begin
            n_fail++;
            $display("FAIL shift_left got %h exp %h",
                     {bus.Data_out, bus.V, bus.C, bus.N, bus.Z}, e_l);
        end
    endtask

    task automatic test_back_to_back();
        apply(16'h6003, 8'h10, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            apply(16'h6C05, 8'h00, 8'h00, 1'b1, 1'b0);
            n_tests++;
            if ({bus.Data_out, bus.done} !== {8'(8'h10 + i), 1'b1}) begin
                n_fail++;
                $display("FAIL b2b_inc%0d got dout=%h done=%b exp %h/1",
                         i, bus.Data_out, bus.done, 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] cw;
        logic [20:0] got;
        logic [20:0] exp;
        for (int i = 0; i < 300; i++) begin
            cw = 16'($urandom);
            apply(cw, 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 9) != 0), 1'b0);
            got = {bus.Data_out, bus.Address_out, bus.done,
                   bus.V, bus.C, bus.N, bus.Z};
            exp = {m_dout, m_aout, m_done, m_v, m_c, m_n, m_z};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random%0d cw=%h got %h exp %h",
                         i, cw, got, exp);
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.control_word = 16'h0000;
        bus.cw_valid     = 1'b0;
        bus.Data_in      = 8'h00;
        bus.constant_in  = 8'h00;
        test_reset();
        test_load();
        test_add();
        test_overflow();
        test_movb_md();
        test_reset_priority();
        test_shift();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
